udp_txbuf_reader: RTL and testbench

Stack-side owner of the UDP TX buffer interface. It accepts a buffer release from the application and reads the header words and payload words over the synchronous `udp_txbuf` read port. It then presents the UDP header fields to the IP/UDP transmit path and streams the payload as bytes with valid/ready flow control. When the frame completes or is aborted, it returns buffer ownership to the application.

---
 rtl/udp_txbuf_reader.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_udp_txbuf_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_txbuf_reader.sv
// UDP TX buffer reader: fetches the header and payload words from the application's
// TX buffer, presents the header to the transmit path and streams the payload as bytes.
module udp_txbuf_reader #(
    parameter int AWIDTH      = 6,
    parameter int MAX_PAYLOAD = (2**AWIDTH-3)*4
) (
    input  logic              clk_int,
    input  logic              rst_n,
    input  logic              txbuf_rel,
    output logic              txbuf_grant,
    output logic [AWIDTH-1:0] txbuf_addr,
    output logic              txbuf_ce,
    input  logic [31:0]       txbuf_rdata,
    output logic              tx_req,
    input  logic              tx_ack,
    input  logic              tx_abort,
    output logic [31:0]       dst_ip,
    output logic [15:0]       src_port,
    output logic [15:0]       dst_port,
    output logic [15:0]       payload_len,
    output logic [15:0]       udp_len,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              len_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_REQ    = 3'd2,
        S_FETCH  = 3'd3,
        S_STREAM = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [15:0]       MAX_LEN      = 16'(MAX_PAYLOAD);
    localparam logic [AWIDTH-1:0] PAYLOAD_BASE = AWIDTH'(3);

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic                grant_q, grant_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic                ce_q, ce_d;
    logic                tx_req_q, tx_req_d;
    logic [31:0]         dst_ip_q, dst_ip_d;
    logic [15:0]         src_port_q, src_port_d;
    logic [15:0]         dst_port_q, dst_port_d;
    logic [15:0]         payload_len_q, payload_len_d;
    logic [15:0]         udp_len_q, udp_len_d;
    logic [31:0]         word_q, word_d;
    logic [15:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                len_err_q, len_err_d;
    logic [15:0]         next_cnt_s;
    logic [15:0]         last_idx_s;

    // Bytes leave a word LSB first.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // State and output registers.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            phase_q       <= 2'd0;
            grant_q       <= 1'b1;
            addr_q        <= '0;
            ce_q          <= 1'b0;
            tx_req_q      <= 1'b0;
            dst_ip_q      <= 32'd0;
            src_port_q    <= 16'd0;
            dst_port_q    <= 16'd0;
            payload_len_q <= 16'd0;
            udp_len_q     <= 16'd0;
            word_q        <= 32'd0;
            byte_cnt_q    <= 16'd0;
            out_data_q    <= 8'd0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            grant_q       <= grant_d;
            addr_q        <= addr_d;
            ce_q          <= ce_d;
            tx_req_q      <= tx_req_d;
            dst_ip_q      <= dst_ip_d;
            src_port_q    <= src_port_d;
            dst_port_q    <= dst_port_d;
            payload_len_q <= payload_len_d;
            udp_len_q     <= udp_len_d;
            word_q        <= word_d;
            byte_cnt_q    <= byte_cnt_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            len_err_q     <= len_err_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        grant_d       = grant_q;
        addr_d        = addr_q;
        ce_d          = ce_q;
        tx_req_d      = tx_req_q;
        dst_ip_d      = dst_ip_q;
        src_port_d    = src_port_q;
        dst_port_d    = dst_port_q;
        payload_len_d = payload_len_q;
        udp_len_d     = udp_len_q;
        word_d        = word_q;
        byte_cnt_d    = byte_cnt_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        len_err_d     = 1'b0;
        next_cnt_s    = byte_cnt_q + 16'd1;
        last_idx_s    = payload_len_q - 16'd1;

        case (state_q)
            S_IDLE: begin
                grant_d = 1'b1;
                ce_d    = 1'b0;
                if (txbuf_rel) begin
                    state_d = S_HDR;
                    phase_d = 2'd0;
                    grant_d = 1'b0;
                    ce_d    = 1'b1;
                    addr_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            // Header words arrive one cycle behind their address.
            S_HDR: begin
                case (phase_q)
                    2'd0: begin
                        addr_d  = AWIDTH'(1);
                        phase_d = 2'd1;
                    end
                    2'd1: begin
                        dst_ip_d = txbuf_rdata;
                        addr_d   = AWIDTH'(2);
                        phase_d  = 2'd2;
                    end
                    2'd2: begin
                        src_port_d = txbuf_rdata[31:16];
                        dst_port_d = txbuf_rdata[15:0];
                        ce_d       = 1'b0;
                        phase_d    = 2'd3;
                    end
                    2'd3: begin
                        payload_len_d = txbuf_rdata[15:0];
                        udp_len_d     = txbuf_rdata[15:0] + 16'd8;
                        byte_cnt_d    = 16'd0;
                        phase_d       = 2'd0;
                        if (txbuf_rdata[15:0] > MAX_LEN) begin
                            len_err_d = 1'b1;
                            grant_d   = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            tx_req_d = 1'b1;
                            state_d  = S_REQ;
                        end
                    end
                    default: begin
                        phase_d = 2'd0;
                    end
                endcase
            end
            S_REQ: begin
                if (tx_abort) begin
                    tx_req_d = 1'b0;
                    grant_d  = 1'b1;
                    state_d  = S_IDLE;
                end else if (tx_ack) begin
                    tx_req_d = 1'b0;
                    if (payload_len_q == 16'd0) begin
                        grant_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        ce_d    = 1'b1;
                        addr_d  = PAYLOAD_BASE;
                        phase_d = 2'd0;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_FETCH: begin
                if (tx_abort) begin
                    ce_d    = 1'b0;
                    grant_d = 1'b1;
                    state_d = S_IDLE;
                end else if (phase_q == 2'd0) begin
                    ce_d    = 1'b0;
                    phase_d = 2'd1;
                end else begin
                    word_d      = txbuf_rdata;
                    out_data_d  = byte_sel(txbuf_rdata, byte_cnt_q[1:0]);
                    out_valid_d = 1'b1;
                    out_last_d  = (byte_cnt_q == last_idx_s);
                    phase_d     = 2'd0;
                    state_d     = S_STREAM;
                end
            end
            S_STREAM: begin
                if (tx_abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    grant_d     = 1'b1;
                    state_d     = S_IDLE;
                end else if (out_ready) begin
                    byte_cnt_d = next_cnt_s;
                    if (byte_cnt_q == last_idx_s) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        grant_d     = 1'b1;
                        state_d     = S_DONE;
                    end else if (byte_cnt_q[1:0] == 2'd3) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        ce_d        = 1'b1;
                        addr_d      = addr_q + AWIDTH'(1);
                        phase_d     = 2'd0;
                        state_d     = S_FETCH;
                    end else begin
                        out_data_d = byte_sel(word_q, next_cnt_s[1:0]);
                        out_last_d = (next_cnt_s == last_idx_s);
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DONE: begin
                grant_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                grant_d     = 1'b1;
                ce_d        = 1'b0;
                tx_req_d    = 1'b0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    assign txbuf_grant = grant_q;
    assign txbuf_addr  = addr_q;
    assign txbuf_ce    = ce_q;
    assign tx_req      = tx_req_q;
    assign dst_ip      = dst_ip_q;
    assign src_port    = src_port_q;
    assign dst_port    = dst_port_q;
    assign payload_len = payload_len_q;
    assign udp_len     = udp_len_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_udp_txbuf_reader.sv
// Self-checking bench for udp_txbuf_reader: directed frame sequence with random
// payloads and flow control, checked against a byte-level model of the buffer contents.
module tb_udp_txbuf_reader;

    localparam int AWIDTH  = 6;
    localparam int MAX_LEN = 244;

    logic              clk_int = 1'b0;
    logic              rst_n;
    logic              txbuf_rel;
    logic              txbuf_grant;
    logic [AWIDTH-1:0] txbuf_addr;
    logic              txbuf_ce;
    logic [31:0]       txbuf_rdata = 32'd0;
    logic              tx_req;
    logic              tx_ack;
    logic              tx_abort;
    logic [31:0]       dst_ip;
    logic [15:0]       src_port;
    logic [15:0]       dst_port;
    logic [15:0]       payload_len;
    logic [15:0]       udp_len;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              len_err;

    logic [31:0] mem [0:63];
    int checks   = 0;
    int failures = 0;

    udp_txbuf_reader dut (
        .clk_int     (clk_int),
        .rst_n       (rst_n),
        .txbuf_rel   (txbuf_rel),
        .txbuf_grant (txbuf_grant),
        .txbuf_addr  (txbuf_addr),
        .txbuf_ce    (txbuf_ce),
        .txbuf_rdata (txbuf_rdata),
        .tx_req      (tx_req),
        .tx_ack      (tx_ack),
        .tx_abort    (tx_abort),
        .dst_ip      (dst_ip),
        .src_port    (src_port),
        .dst_port    (dst_port),
        .payload_len (payload_len),
        .udp_len     (udp_len),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .len_err     (len_err)
    );

    always #5 clk_int = ~clk_int;

    // Synchronous-read buffer owned by the application side.
    always @(posedge clk_int) begin
        if (txbuf_ce) txbuf_rdata <= mem[txbuf_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = mem[3 + i / 4];
        return 8'(w >> (8 * (i % 4)));
    endfunction

    task automatic step();
        @(posedge clk_int);
        #1;
    endtask

    task automatic load_fixed();
        mem[0] = 32'h0a01a8c0;
        mem[1] = 32'h045704d2;
        mem[2] = 32'h0000000f;
        mem[3] = 32'h20504455;
        mem[4] = 32'h646e6553;
        mem[5] = 32'h73655420;
        mem[6] = 32'h00000a74;
    endtask

    task automatic load_random(input int len);
        mem[0] = $urandom;
        mem[1] = $urandom;
        mem[2] = {16'd0, 16'(len)};
        for (int i = 3; i < 64; i++) mem[i] = $urandom;
    endtask

    // One frame from release to completion, abort or reset (-1 disables a feature).
    task automatic run_frame(input int len, input bit rnd_ready, input int abort_at,
                             input int rst_at, input int rel_at);
        int idx, cyc, last_b3;
        bit prev_stall, done, fin, rdy, rel_sent, rel_pending;
        logic [7:0] prev_data;
        logic prev_last;

        txbuf_rel = 1'b1;
        step();
        txbuf_rel = 1'b0;
        check("hdr_grant_t1", 32'(txbuf_grant), 32'd0);
        check("hdr_ce_t1", 32'(txbuf_ce), 32'd1);
        check("hdr_addr_t1", 32'(txbuf_addr), 32'd0);
        step();
        check("hdr_addr_t2", 32'(txbuf_addr), 32'd1);
        step();
        check("hdr_addr_t3", 32'(txbuf_addr), 32'd2);
        step();
        check("hdr_ce_t4", 32'(txbuf_ce), 32'd0);
        step();
        if (len > MAX_LEN) begin
            check("lenerr_pulse", 32'(len_err), 32'd1);
            check("lenerr_grant", 32'(txbuf_grant), 32'd1);
            check("lenerr_txreq", 32'(tx_req), 32'd0);
            step();
            check("lenerr_one_cycle", 32'(len_err), 32'd0);
            check("lenerr_txreq2", 32'(tx_req), 32'd0);
            return;
        end
        check("req_txreq", 32'(tx_req), 32'd1);
        check("req_lenerr", 32'(len_err), 32'd0);
        check("req_dst_ip", dst_ip, mem[0]);
        check("req_src_port", 32'(src_port), {16'd0, mem[1][31:16]});
        check("req_dst_port", 32'(dst_port), {16'd0, mem[1][15:0]});
        check("req_payload_len", 32'(payload_len), 32'(16'(len)));
        check("req_udp_len", 32'(udp_len), 32'(16'(len + 8)));
        step();
        step();
        check("req_hold", 32'(tx_req), 32'd1);
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
        check("ack_txreq_low", 32'(tx_req), 32'd0);
        if (len == 0) begin
            check("zero_grant", 32'(txbuf_grant), 32'd1);
            for (int k = 0; k < 4; k++) begin
                check("zero_no_valid", 32'(out_valid), 32'd0);
                step();
            end
            return;
        end
        check("fetch_ce", 32'(txbuf_ce), 32'd1);
        check("fetch_addr", 32'(txbuf_addr), 32'd3);
        check("fetch_grant", 32'(txbuf_grant), 32'd0);
        check("fetch_valid_a1", 32'(out_valid), 32'd0);
        step();
        check("fetch_valid_a2", 32'(out_valid), 32'd0);
        step();
        check("first_valid_a3", 32'(out_valid), 32'd1);

        idx = 0; cyc = 0; last_b3 = -1; prev_stall = 1'b0; done = 1'b0;
        rel_sent = 1'b0; rel_pending = 1'b0; prev_data = 8'd0; prev_last = 1'b0;
        while (!done && cyc < 4000) begin
            if (rst_at == idx && out_valid) begin
                rst_n = 1'b0;
                #1;
                check("rst_grant", 32'(txbuf_grant), 32'd1);
                check("rst_txreq", 32'(tx_req), 32'd0);
                check("rst_valid", 32'(out_valid), 32'd0);
                check("rst_last", 32'(out_last), 32'd0);
                check("rst_data", 32'(out_data), 32'd0);
                check("rst_ce", 32'(txbuf_ce), 32'd0);
                check("rst_addr", 32'(txbuf_addr), 32'd0);
                check("rst_dst_ip", dst_ip, 32'd0);
                check("rst_udp_len", 32'(udp_len), 32'd0);
                out_ready = 1'b0;
                step();
                rst_n = 1'b1;
                step();
                return;
            end
            if (rel_pending) begin
                txbuf_rel = 1'b0;
                rel_pending = 1'b0;
                check("rel_ignored_grant", 32'(txbuf_grant), 32'd0);
            end
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && last_b3 >= 0) begin
                check("word_gap", 32'(cyc - last_b3), 32'd3);
                last_b3 = -1;
            end
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (rel_at == idx && out_valid && !rel_sent) begin
                txbuf_rel = 1'b1;
                rel_sent = 1'b1;
                rel_pending = 1'b1;
            end
            if (out_valid && rdy && idx == abort_at) begin
                tx_abort = 1'b1;
                step();
                tx_abort = 1'b0;
                txbuf_rel = 1'b0;
                check("abort_valid", 32'(out_valid), 32'd0);
                check("abort_grant", 32'(txbuf_grant), 32'd1);
                check("abort_txreq", 32'(tx_req), 32'd0);
                done = 1'b1;
            end else begin
                fin = 1'b0;
                if (out_valid && rdy) begin
                    check("byte_data", 32'(out_data), 32'(exp_byte(idx)));
                    check("byte_last", 32'(out_last), 32'(idx == len - 1));
                    if (idx == len - 1) begin
                        check("last_word_addr", 32'(txbuf_addr), 32'(3 + (len - 1) / 4));
                        fin = 1'b1;
                    end else if (idx % 4 == 3) begin
                        last_b3 = cyc;
                    end
                    idx++;
                end
                prev_stall = out_valid && !rdy;
                prev_data  = out_data;
                prev_last  = out_last;
                step();
                cyc++;
                if (fin) begin
                    check("done_grant", 32'(txbuf_grant), 32'd1);
                    check("done_valid", 32'(out_valid), 32'd0);
                    check("byte_count", 32'(idx), 32'(len));
                    done = 1'b1;
                end
            end
        end
        check("stream_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; txbuf_rel = 1'b0; tx_ack = 1'b0; tx_abort = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clk_int);
        #1;
        check("reset_grant", 32'(txbuf_grant), 32'd1);
        check("reset_txreq", 32'(tx_req), 32'd0);
        check("reset_ce", 32'(txbuf_ce), 32'd0);
        check("reset_addr", 32'(txbuf_addr), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'(out_data), 32'd0);
        check("reset_lenerr", 32'(len_err), 32'd0);
        check("reset_dst_ip", dst_ip, 32'd0);
        check("reset_udp_len", 32'(udp_len), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        check("idle_grant", 32'(txbuf_grant), 32'd1);

        load_fixed();
        run_frame(15, 1'b0, -1, -1, -1);
        step();
        step();
        check("plan_dst_ip", dst_ip, 32'h0a01a8c0);
        check("plan_src_port", 32'(src_port), 32'd1111);
        check("plan_dst_port", 32'(dst_port), 32'd1234);
        check("plan_udp_len", 32'(udp_len), 32'd23);
        step();

        load_fixed();
        run_frame(15, 1'b1, -1, -1, -1);
        repeat (3) step();

        load_random(245);
        run_frame(245, 1'b0, -1, -1, -1);
        repeat (3) step();

        load_random(244);
        run_frame(244, 1'b1, -1, -1, -1);
        repeat (3) step();

        load_random(0);
        run_frame(0, 1'b0, -1, -1, -1);
        repeat (3) step();

        load_random(40);
        run_frame(40, 1'b0, 6, -1, 3);
        repeat (3) step();

        load_random(37);
        run_frame(37, 1'b1, -1, -1, -1);
        repeat (3) step();

        for (int f = 0; f < 4; f++) begin
            int rlen;
            rlen = $urandom_range(1, MAX_LEN);
            load_random(rlen);
            run_frame(rlen, 1'b1, -1, -1, -1);
            repeat (3) step();
        end

        load_random(50);
        run_frame(50, 1'b1, -1, 9, -1);
        repeat (3) step();

        load_random(23);
        run_frame(23, 1'b1, -1, -1, -1);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
